// File: rtl/rh_gpv_collector_pkg.sv
// Shared types and constants for the GPV vector-in collector.
package rh_gpv_collector_pkg;

  localparam int unsigned RHGPV_MAX_VECTOR_WIDTH = 1024;
  localparam int unsigned DROP_CNT_W             = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    QUAL = 1'b1
  } state_e;

  // Saturating increment for the dropped-event counter.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/rh_gpv_event_fifo.sv
// Synchronous event FIFO with wrap-bit pointers; head entry is presented directly.
module rh_gpv_event_fifo #(
  parameter int unsigned DEPTH   = 8,
  parameter type         entry_t = logic [7:0]
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  entry_t                 push_data_i,
  input  logic                   pop_i,
  output entry_t                 head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic          do_push_c;
  logic          do_pop_c;

  assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o   = (wptr_q == rptr_q);
  assign level_o   = wptr_q - rptr_q;
  assign head_o    = mem_q[rptr_q[AW-1:0]];
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop_c  = pop_i && !empty_o;
  assign do_push_c = push_i && (!full_o || do_pop_c);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push_c) wptr_d = wptr_q + (AW+1)'(1);
    if (do_pop_c)  rptr_d = rptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
    end else if (do_push_c) begin
      mem_q[wptr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/rh_gpv_vector_collector.sv
// GPV vector-in collector: masks and samples a DUT vector, filters glitches with a
// programmable stability window, and queues timestamped change events.
module rh_gpv_vector_collector
  import rh_gpv_collector_pkg::*;
#(
  parameter int unsigned VEC_W    = 32,
  parameter int unsigned TS_W     = 16,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned STABLE_W = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic [STABLE_W-1:0]    stable_cycles_i,
  input  logic [VEC_W-1:0]       mask_i,
  input  logic [VEC_W-1:0]       vector_in_i,
  output logic                   ev_valid_o,
  input  logic                   ev_ready_i,
  output logic [VEC_W-1:0]       ev_vector_o,
  output logic [TS_W-1:0]        ev_ts_o,
  output logic                   ev_ovf_o,
  output logic [$clog2(DEPTH):0] ev_level_o,
  output logic [DROP_CNT_W-1:0]  drop_count_o
);

  typedef struct packed {
    logic [VEC_W-1:0] vector;
    logic [TS_W-1:0]  ts;
    logic             ovf;
  } entry_t;

  state_e                state_q, state_d;
  logic [VEC_W-1:0]      s1_q;
  logic [VEC_W-1:0]      ref_q, ref_d;
  logic [VEC_W-1:0]      cand_q, cand_d;
  logic [STABLE_W-1:0]   cnt_q, cnt_d;
  logic [TS_W-1:0]       ts_cand_q, ts_cand_d;
  logic [TS_W-1:0]       tsc_q, tsc_d;
  logic                  pending_ovf_q, pending_ovf_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic   diff_ref_c;
  logic   match_cand_c;
  logic   cnt_done_c;
  logic   commit_c;
  logic   pop_c;
  logic   drop_c;
  logic   accept_c;
  logic   full_c;
  logic   empty_c;
  entry_t push_entry_c;
  entry_t head_c;

  assign diff_ref_c   = (s1_q != ref_q);
  assign match_cand_c = (s1_q == cand_q);
  assign cnt_done_c   = (cnt_q >= stable_cycles_i);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; disabling collection always parks the filter.
  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (diff_ref_c) state_d = QUAL;
        QUAL:    if (!diff_ref_c || commit_c) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Filter datapath and commit decision.
  always_comb begin
    commit_c  = 1'b0;
    ref_d     = ref_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    ts_cand_d = ts_cand_q;
    if (!enable_i) begin
      ref_d = s1_q;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (diff_ref_c) begin
            cand_d    = s1_q;
            cnt_d     = '0;
            ts_cand_d = tsc_q;
          end
        end
        QUAL: begin
          if (diff_ref_c) begin
            if (!match_cand_c) begin
              cand_d    = s1_q;
              cnt_d     = '0;
              ts_cand_d = tsc_q;
            end else if (cnt_done_c) begin
              commit_c = 1'b1;
              ref_d    = cand_q;
            end else begin
              cnt_d = cnt_q + STABLE_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign pop_c    = ev_valid_o && ev_ready_i;
  assign drop_c   = commit_c && full_c && !pop_c;
  assign accept_c = commit_c && !drop_c;

  always_comb begin
    push_entry_c        = '0;
    push_entry_c.vector = cand_q;
    push_entry_c.ts     = ts_cand_q;
    push_entry_c.ovf    = pending_ovf_q;
  end

  // Timestamp and overflow bookkeeping.
  always_comb begin
    tsc_d         = enable_i ? tsc_q + TS_W'(1) : tsc_q;
    pending_ovf_d = pending_ovf_q;
    drop_cnt_d    = drop_cnt_q;
    if (drop_c) begin
      pending_ovf_d = 1'b1;
      drop_cnt_d    = sat_inc(drop_cnt_q);
    end else if (accept_c) begin
      pending_ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q          <= '0;
      ref_q         <= '0;
      cand_q        <= '0;
      cnt_q         <= '0;
      ts_cand_q     <= '0;
      tsc_q         <= '0;
      pending_ovf_q <= 1'b0;
      drop_cnt_q    <= '0;
    end else begin
      s1_q          <= vector_in_i & mask_i;
      ref_q         <= ref_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      ts_cand_q     <= ts_cand_d;
      tsc_q         <= tsc_d;
      pending_ovf_q <= pending_ovf_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  rh_gpv_event_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (commit_c),
    .push_data_i (push_entry_c),
    .pop_i       (pop_c),
    .head_o      (head_c),
    .full_o      (full_c),
    .empty_o     (empty_c),
    .level_o     (ev_level_o)
  );

  assign ev_valid_o   = !empty_c;
  assign ev_vector_o  = head_c.vector;
  assign ev_ts_o      = head_c.ts;
  assign ev_ovf_o     = head_c.ovf;
  assign drop_count_o = drop_cnt_q;

endmodule

// File: tb/tb_rh_gpv_vector_collector.sv
// Scoreboard bench for rh_gpv_vector_collector using a run-length reference model.
module tb_rh_gpv_vector_collector;

  localparam int unsigned VEC_W = 32;
  localparam int unsigned TS_W  = 16;
  localparam int unsigned DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic [3:0]       stable = 4'd0;
  logic [VEC_W-1:0] mask = '1;
  logic [VEC_W-1:0] vin = '0;
  logic             ev_ready = 1'b0;
  logic             ev_valid;
  logic [VEC_W-1:0] ev_vector;
  logic [TS_W-1:0]  ev_ts;
  logic             ev_ovf;
  logic [3:0]       ev_level;
  logic [7:0]       drop_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [VEC_W-1:0] v;
    logic [TS_W-1:0]  ts;
    logic             ovf;
  } exp_t;
  exp_t sb_q[$];

  // Reference model state: committed value, current run of equal samples.
  logic [VEC_W-1:0] m_s1 = '0;
  logic [VEC_W-1:0] m_ref = '0;
  logic [VEC_W-1:0] run_val = '0;
  int               run_len = 0;
  logic [TS_W-1:0]  run_ts = '0;
  logic [TS_W-1:0]  m_tsc = '0;
  logic             m_pend = 1'b0;
  int               m_occ = 0;
  logic [7:0]       m_drop = '0;

  rh_gpv_vector_collector #(
    .VEC_W(VEC_W), .TS_W(TS_W), .DEPTH(DEPTH), .STABLE_W(4)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .enable_i        (enable),
    .stable_cycles_i (stable),
    .mask_i          (mask),
    .vector_in_i     (vin),
    .ev_valid_o      (ev_valid),
    .ev_ready_i      (ev_ready),
    .ev_vector_o     (ev_vector),
    .ev_ts_o         (ev_ts),
    .ev_ovf_o        (ev_ovf),
    .ev_level_o      (ev_level),
    .drop_count_o    (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // A value becomes committed once it has been observed stable_cycles+2 times in a row.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = '0; m_ref = '0; run_val = '0; run_len = 0; run_ts = '0;
      m_tsc = '0; m_pend = 1'b0; m_occ = 0; m_drop = '0;
      sb_q.delete();
    end else begin
      bit pop, push;
      exp_t e;
      pop  = (m_occ > 0) && ev_ready;
      push = 1'b0;
      if (enable) begin
        if (run_len != 0 && m_s1 == run_val) run_len++;
        else begin
          run_val = m_s1;
          run_len = 1;
          run_ts  = m_tsc;
        end
        if (run_val != m_ref && run_len >= int'(stable) + 2) begin
          push  = 1'b1;
          m_ref = run_val;
        end
        m_tsc = m_tsc + 16'd1;
      end else begin
        m_ref   = m_s1;
        run_len = 0;
      end
      if (push) begin
        if (m_occ < int'(DEPTH) || pop) begin
          e.v = run_val; e.ts = run_ts; e.ovf = m_pend;
          sb_q.push_back(e);
          m_pend = 1'b0;
          m_occ++;
        end else begin
          m_pend = 1'b1;
          if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
        end
      end
      if (pop) m_occ--;
      m_s1 = vin & mask;
    end
  end

  // Monitor: handshake pops the scoreboard; status compared every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ev_valid", 64'(ev_valid), 64'(m_occ != 0));
      chk("ev_level", 64'(ev_level), 64'(m_occ));
      chk("drop_count", 64'(drop_count), 64'(m_drop));
      if (ev_valid && ev_ready) begin
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_event: got vector 0x%0h expected none", ev_vector);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("ev_vector", 64'(ev_vector), 64'(e.v));
          chk("ev_ts", 64'(ev_ts), 64'(e.ts));
          chk("ev_ovf", 64'(ev_ovf), 64'(e.ovf));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Counts edges from the one that samples a new vin until ev_valid is seen.
  task automatic latency(input string name, input int exp_cyc);
    int cyc;
    cyc = 99;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ev_valid) begin
        cyc = i;
        break;
      end
    end
    chk(name, 64'(cyc), 64'(exp_cyc));
  endtask

  initial begin
    tick(3);
    rst_n = 1'b1;
    enable = 1'b1; stable = 4'd0; mask = '1; ev_ready = 1'b1; vin = '0;
    tick(3);

    // Basic commit with zero stability window.
    vin = 32'h0000_00A5;
    latency("latency_s0", 3);
    tick(4);
    vin = '0;
    tick(5);

    // Glitch rejection, then qualified change.
    stable = 4'd3;
    vin = 32'h1; tick(2);
    vin = 32'h0; tick(6);
    vin = 32'h1;
    latency("latency_s3", 6);
    tick(4);

    // Masked-off bits never create events.
    stable = 4'd0;
    mask = 32'hFFFF_0000;
    tick(4);
    for (int i = 0; i < 20; i++) begin
      vin = {16'h0000, 16'($urandom)};
      tick(1);
    end
    vin = 32'h0001_0000 | 32'($urandom_range(0, 16'hFFFF));
    tick(5);
    mask = '1;
    vin = '0;
    tick(6);

    // Overflow: 10 commits against a stalled consumer.
    ev_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      vin = 32'h100 + 32'(i);
      tick(3);
    end
    chk("level_full", 64'(ev_level), 64'd8);
    chk("drop_two", 64'(drop_count), 64'd2);
    ev_ready = 1'b1;
    tick(12);
    vin = 32'h200;
    tick(6);

    // Disabled window: no events, timestamp frozen.
    enable = 1'b0;
    vin = 32'h5; tick(3);
    vin = 32'h9; tick(3);
    enable = 1'b1;
    tick(4);
    vin = 32'h33;
    tick(6);

    // Async reset with queued entries and an in-flight qualification.
    ev_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vin = 32'h40 + 32'(i);
      tick(3);
    end
    stable = 4'd7;
    vin = 32'h77;
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(ev_valid), 64'd0);
    chk("rst_level", 64'(ev_level), 64'd0);
    chk("rst_drops", 64'(drop_count), 64'd0);
    tick(2);
    vin = 32'h42;
    rst_n = 1'b1;
    ev_ready = 1'b1;
    tick(14);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) vin = 32'($urandom_range(0, 3));
      enable   = ($urandom_range(0, 9) != 0);
      stable   = 4'($urandom_range(0, 3));
      ev_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0) mask = ($urandom_range(0, 1) != 0) ? '1 : 32'h2;
      tick(1);
    end
    enable = 1'b1; ev_ready = 1'b1; stable = 4'd0;
    tick(40);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rh_gpv_vector_collector.md
Name: rh_gpv_vector_collector

Overview:
Synthesizable collector for the GPV vector-in path. It samples a DUT-driven vector, filters glitches with a programmable stability window, and timestamps each committed change. Change events are queued in a small FIFO and presented on a valid/ready stream. It sits between the DUT's vector outputs and the monitor side of the GPV agent, as the receive-direction counterpart of the vector driver.

Parameters:
VEC_W, 32, vector width (≤ RHGPV_MAX_VECTOR_WIDTH)
TS_W, 16, timestamp counter width
DEPTH, 8, event FIFO entries (power of 2, ≥2)
STABLE_W, 4, width of stability-window control

Ports:
clock  input  1  sole clock, all state on posedge
reset  input  1  asynchronous, active-low reset
enable  input  1  collection enable
stable_cycles  input  STABLE_W  extra cycles a new value must hold before commit
mask  input  VEC_W  per-bit compare mask (1 = bit observed)
vector_in  input  VEC_W  DUT-driven vector, synchronous to clock
ev_valid  output  1  FIFO head holds an event
ev_ready  input  1  consumer accepts head
ev_vector  output  VEC_W  committed masked vector value
ev_ts  output  TS_W  timestamp of change detection
ev_ovf  output  1  one or more events were dropped before this one
ev_level  output  $clog2(DEPTH)+1  FIFO occupancy
drop_count  output  8  saturating count of dropped events

Behaviour:
- Reset (reset=0, async): s1, ref, cand, cnt, tsc, FIFO pointers, pending_ovf, drop_count = 0. State is IDLE, ev_valid=0, ev_level=0, ev_vector/ev_ts/ev_ovf=0.
- Sample stage: s1 <= vector_in & mask on every edge, regardless of enable.
- Timestamp: tsc increments by 1 on each edge while enable=1. It wraps modulo 2^TS_W and holds while enable=0.
- enable=0: FSM is forced to IDLE, ref <= s1, no pushes. Re-enabling therefore never produces a spurious event. If enable=1 directly out of reset, ref=0, so a nonzero first sample produces an event.
- FSM IDLE: if s1 != ref, then QUAL, cand <= s1, cnt <= 0, ts_cand <= tsc.
- FSM QUAL, per edge:
  - s1 == ref (glitch returned): go to IDLE, no event.
  - s1 != cand and s1 != ref: cand <= s1, cnt <= 0, ts_cand <= tsc, stay in QUAL.
  - s1 == cand and cnt == stable_cycles: commit (ref <= cand, push {cand, ts_cand, pending_ovf}), go to IDLE.
  - s1 == cand otherwise: cnt++.
- Latency: vector_in changes before edge k and is held. s1 updates at k, QUAL at k+1, commit at k+2+stable_cycles, and ev_valid=1 after that edge when the FIFO was empty.
- stable_cycles is sampled live. Lowering it below the current cnt commits on the next matching edge (compare uses cnt >= stable_cycles).
- Mask changes act through s1 and may themselves create events.
- FIFO: ev_* driven from the head entry. Pop on ev_valid & ev_ready. Head outputs hold stable while ev_valid & !ev_ready.
- Push while full with no pop in the same cycle: the entry is dropped, drop_count increments (saturates at 255), pending_ovf <= 1. The next accepted push carries ovf=1 and clears pending_ovf.
- Push and pop in the same cycle while full: both are accepted and the level is unchanged.
- Push and pop in the same cycle while empty: the push is accepted, ev_valid=1 next cycle, and the pop is a no-op because ev_valid was 0.
- Pointers are $clog2(DEPTH)+1 bits with wrap bit. full = MSBs differ and LSBs equal.

Decomposition:
- Package rh_gpv_collector_pkg holds:
  - enum state_e {IDLE, QUAL}
  - parameterized struct/typedef for an event entry {vector, ts, ovf}
  - DROP_CNT_W = 8
- Sub-module rh_gpv_event_fifo (sync FIFO, DEPTH × entry, push/pop/full/empty/level). Filter FSM, timestamp and drop logic stay in the top level.

Test Plan:
- Reset, enable=1, stable_cycles=0, mask='1, vector_in 0→0x0000_00A5 held: exactly one event {0xA5, ts=detection tsc, ovf=0}, ev_valid rises 2 cycles after the sampling edge.
- stable_cycles=3, 2-cycle pulse 0→0x1→0: no event. Then hold 0x1 for 6 cycles: one event, ev_valid at k+5.
- mask=0xFFFF_0000, toggle bits [15:0] randomly: no events. Change bit 16: event with ev_vector=0x0001_0000.
- ev_ready=0, DEPTH=8, 10 committed changes: ev_level=8 and drop_count=2. Then ev_ready=1 plus one more change: the 9th delivered event has ovf=1, the first 8 have ovf=0.
- enable=0 while vector changes 0x5→0x9, then enable=1: no event, and tsc is unchanged across the disabled window.
- Assert reset mid-QUAL and with the FIFO holding 3 entries: ev_valid=0 and ev_level=0 immediately (async). After release, a nonzero held vector yields one event with ts counted from 0.
